// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the Folio CPU ALU: datapath width and the 4-bit
// function-code encodings decoded by the top level.
// ---------------------------------------------------------------------------
package alu_pkg;

    // Datapath width; the function-code table below assumes 16 bits.
    localparam int ALU_WIDTH = 16;

    typedef logic [3:0] func_code_t;

    localparam func_code_t FC_ADD = 4'b0000;
    localparam func_code_t FC_SUB = 4'b0001;
    localparam func_code_t FC_AND = 4'b0010;
    localparam func_code_t FC_OR  = 4'b0011;
    localparam func_code_t FC_MUL = 4'b0100;
    localparam func_code_t FC_DIV = 4'b0101;

endpackage : alu_pkg

// File: rtl/alu_muldiv.sv
// ---------------------------------------------------------------------------
// alu_muldiv
// Purely combinational signed multiplier and signed divider.
//
// Ports:
//   a_i        : signed operand A (multiplicand / dividend)
//   b_i        : signed operand B (multiplier / divisor)
//   prod_lo_o  : low word of the full-width signed product
//   prod_hi_o  : high word of the full-width signed product
//   quot_o     : quotient, truncated toward zero
//   rem_o      : remainder, carrying the sign of the dividend
//   div_zero_o : divisor is zero (quotient/remainder meaningless)
//   div_ovf_o  : most-negative / -1 (quotient not representable)
// ---------------------------------------------------------------------------
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] prod_lo_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             div_zero_o,
    output logic             div_ovf_o
);

    // Sign-extend both operands to double width; the low 2*WIDTH bits of the
    // product of sign-extended values are the exact signed product.
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;

    assign a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_ext = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign prod  = a_ext * b_ext;

    assign prod_lo_o = prod[WIDTH-1:0];
    assign prod_hi_o = prod[2*WIDTH-1:WIDTH];

    logic [WIDTH-1:0] min_neg;
    assign min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    assign div_zero_o = (b_i == '0);
    assign div_ovf_o  = (a_i == min_neg) && (b_i == '1);

    // In either corner case the divider is fed a divisor of 1 so it never
    // sees x/0 and min/-1 yields quotient = min, remainder = 0 directly.
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_safe;
    logic signed [WIDTH-1:0] quot_s;
    logic signed [WIDTH-1:0] rem_s;

    assign a_s    = a_i;
    assign b_safe = (div_zero_o || div_ovf_o) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_i;
    assign quot_s = a_s / b_safe;
    assign rem_s  = a_s % b_safe;

    assign quot_o = quot_s;
    assign rem_o  = div_ovf_o ? '0 : rem_s;

endmodule : alu_muldiv

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// 16-bit signed ALU for the Folio CPU. One result per enabled cycle, with
// registered result, R15 secondary word and err/neg/zero status flags.
//
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : synchronous active-low reset (priority over alu_op)
//   function_code : operation select (ADD/SUB/AND/OR/MUL/DIV, others illegal)
//   op1, op2      : signed operands
//   alu_op        : 1 = update all outputs at this edge, 0 = hold
//   out           : primary result
//   r15           : product high word (MUL) or remainder (DIV)
//   err           : overflow / divide error / illegal code
//   neg           : sign bit of registered out
//   zero          : registered out equals zero
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       function_code,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             alu_op,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] r15,
    output logic             err,
    output logic             neg,
    output logic             zero
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] r15_q, r15_d;
    logic             err_q, err_d;
    logic             neg_q;
    logic             zero_q;

    // Multiply / divide datapath
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_zero;
    logic             div_ovf;

    alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .a_i        (op1),
        .b_i        (op2),
        .prod_lo_o  (prod_lo),
        .prod_hi_o  (prod_hi),
        .quot_o     (quot),
        .rem_o      (rem),
        .div_zero_o (div_zero),
        .div_ovf_o  (div_ovf)
    );

    // Add / subtract with signed-overflow detection from the sign bits
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign sum     = op1 + op2;
    assign diff    = op1 - op2;
    assign add_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1]  != op1[WIDTH-1]);
    assign sub_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);

    // Opcode mux: r15 only changes for MUL and a non-zero-divisor DIV.
    always_comb begin
        out_d = '0;
        r15_d = r15_q;
        err_d = 1'b0;
        case (function_code)
            FC_ADD: begin
                out_d = sum;
                err_d = add_ovf;
            end
            FC_SUB: begin
                out_d = diff;
                err_d = sub_ovf;
            end
            FC_AND: out_d = op1 & op2;
            FC_OR:  out_d = op1 | op2;
            FC_MUL: begin
                out_d = prod_lo;
                r15_d = prod_hi;
            end
            FC_DIV: begin
                if (div_zero) begin
                    err_d = 1'b1;
                end else begin
                    out_d = quot;
                    r15_d = rem;
                    err_d = div_ovf;
                end
            end
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            r15_q  <= '0;
            err_q  <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b1;
        end else if (alu_op) begin
            out_q  <= out_d;
            r15_q  <= r15_d;
            err_q  <= err_d;
            neg_q  <= out_d[WIDTH-1];
            zero_q <= (out_d == '0);
        end
    end

    assign out  = out_q;
    assign r15  = r15_q;
    assign err  = err_q;
    assign neg  = neg_q;
    assign zero = zero_q;

endmodule : alu

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Directed plus randomized checks of the ALU against an integer-arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  fc;
    logic [15:0] op1, op2;
    logic        alu_op;
    logic [15:0] out, r15;
    logic        err, neg, zero;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state
    logic [15:0] m_out, m_r15;
    logic        m_err;

    alu #(.WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .function_code (fc),
        .op1           (op1),
        .op2           (op2),
        .alu_op        (alu_op),
        .out           (out),
        .r15           (r15),
        .err           (err),
        .neg           (neg),
        .zero          (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference: plain integer arithmetic on the signed operand values.
    task automatic model_apply(input logic r, input logic en, input logic [3:0] f,
                               input logic [15:0] a_v, input logic [15:0] b_v);
        int a, b, res, q, rm;
        a = int'($signed(a_v));
        b = int'($signed(b_v));
        if (!r) begin
            m_out = 16'h0000; m_r15 = 16'h0000; m_err = 1'b0;
        end else if (en) begin
            case (f)
                4'd0: begin
                    res = a + b;
                    m_out = res[15:0];
                    m_err = (res > 32767) || (res < -32768);
                end
                4'd1: begin
                    res = a - b;
                    m_out = res[15:0];
                    m_err = (res > 32767) || (res < -32768);
                end
                4'd2: begin m_out = a_v & b_v; m_err = 1'b0; end
                4'd3: begin m_out = a_v | b_v; m_err = 1'b0; end
                4'd4: begin
                    res   = a * b;
                    m_out = res[15:0];
                    m_r15 = res[31:16];
                    m_err = 1'b0;
                end
                4'd5: begin
                    if (b == 0) begin
                        m_out = 16'h0000; m_err = 1'b1;
                    end else begin
                        q  = a / b;
                        rm = a % b;
                        if (q > 32767) begin
                            m_out = 16'h8000; m_r15 = 16'h0000; m_err = 1'b1;
                        end else begin
                            m_out = q[15:0]; m_r15 = rm[15:0]; m_err = 1'b0;
                        end
                    end
                end
                default: begin m_out = 16'h0000; m_err = 1'b1; end
            endcase
        end
    endtask

    task automatic step(input string ctx, input logic r, input logic en, input logic [3:0] f,
                        input logic [15:0] a_v, input logic [15:0] b_v);
        @(negedge clk);
        rst_n = r; alu_op = en; fc = f; op1 = a_v; op2 = b_v;
        @(posedge clk);
        model_apply(r, en, f, a_v, b_v);
        #1;
        $display("%s rst_n=%b en=%b fc=%h op1=%h op2=%h -> out=%h r15=%h err=%b neg=%b zero=%b",
                 ctx, r, en, f, a_v, b_v, out, r15, err, neg, zero);
        chk({ctx, ".out"},  out,                  m_out);
        chk({ctx, ".r15"},  r15,                  m_r15);
        chk({ctx, ".err"},  {15'd0, err},         {15'd0, m_err});
        chk({ctx, ".neg"},  {15'd0, neg},         {15'd0, m_out[15]});
        chk({ctx, ".zero"}, {15'd0, zero},        {15'd0, (m_out == 16'h0000)});
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0]  rf;
        logic [15:0] ra, rb;
        logic        ren, rr;

        rst_n = 1'b0; alu_op = 1'b0; fc = 4'd0; op1 = '0; op2 = '0;
        m_out = '0; m_r15 = '0; m_err = 1'b0;

        // Reset state
        step("reset0", 1'b0, 1'b0, FC_ADD, 16'h0000, 16'h0000);
        step("reset1", 1'b0, 1'b1, FC_ADD, 16'h1234, 16'h1111);
        chk("reset.out",  out, 16'h0000);
        chk("reset.zero", {15'd0, zero}, 16'h0001);

        // Basic operations with literal expectations
        step("add", 1'b1, 1'b1, FC_ADD, 16'h0100, 16'h0001);
        chk("add.lit.out", out, 16'h0101);
        chk("add.lit.r15", r15, 16'h0000);
        step("sub", 1'b1, 1'b1, FC_SUB, 16'h0100, 16'h0010);
        chk("sub.lit.out", out, 16'h00F0);
        step("mul", 1'b1, 1'b1, FC_MUL, 16'h0100, 16'h0010);
        chk("mul.lit.out", out, 16'h1000);
        step("div", 1'b1, 1'b1, FC_DIV, 16'h0100, 16'h0010);
        chk("div.lit.out", out, 16'h0010);
        step("and", 1'b1, 1'b1, FC_AND, 16'hF0F0, 16'h3C3C);
        chk("and.lit.out", out, 16'h3030);
        step("or", 1'b1, 1'b1, FC_OR, 16'hF000, 16'h000F);
        chk("or.lit.out", out, 16'hF00F);

        // Overflow and wide product
        step("add_ovf", 1'b1, 1'b1, FC_ADD, 16'h7FFF, 16'h0001);
        chk("add_ovf.lit.out", out, 16'h8000);
        chk("add_ovf.lit.err", {15'd0, err}, 16'h0001);
        step("sub_ovf", 1'b1, 1'b1, FC_SUB, 16'h8000, 16'h0001);
        chk("sub_ovf.lit.out", out, 16'h7FFF);
        chk("sub_ovf.lit.err", {15'd0, err}, 16'h0001);
        step("mul_wide", 1'b1, 1'b1, FC_MUL, 16'h4000, 16'h0004);
        chk("mul_wide.lit.r15", r15, 16'h0001);
        chk("mul_wide.lit.zero", {15'd0, zero}, 16'h0001);

        // Signed divide and its corner cases
        step("div_neg", 1'b1, 1'b1, FC_DIV, 16'hFFF9, 16'h0002);
        chk("div_neg.lit.out", out, 16'hFFFD);
        chk("div_neg.lit.r15", r15, 16'hFFFF);
        step("div_zero", 1'b1, 1'b1, FC_DIV, 16'h0005, 16'h0000);
        chk("div_zero.lit.r15", r15, 16'hFFFF);
        chk("div_zero.lit.err", {15'd0, err}, 16'h0001);
        step("div_ovf", 1'b1, 1'b1, FC_DIV, 16'h8000, 16'hFFFF);
        chk("div_ovf.lit.out", out, 16'h8000);
        chk("div_ovf.lit.r15", r15, 16'h0000);

        // Hold, illegal code, reset over an enabled op
        step("hold0", 1'b1, 1'b0, FC_ADD, 16'h1234, 16'h5678);
        step("hold1", 1'b1, 1'b0, FC_MUL, 16'h7777, 16'h0003);
        chk("hold.lit.out", out, 16'h8000);
        step("mul_r15", 1'b1, 1'b1, FC_MUL, 16'hFFFF, 16'h0002);
        step("illegal", 1'b1, 1'b1, 4'b1010, 16'h1234, 16'h5678);
        chk("illegal.lit.out", out, 16'h0000);
        chk("illegal.lit.r15", r15, 16'hFFFF);
        step("add_clr", 1'b1, 1'b1, FC_ADD, 16'h0001, 16'h0001);
        step("rst_en", 1'b0, 1'b1, FC_ADD, 16'h0100, 16'h0001);
        chk("rst_en.lit.out", out, 16'h0000);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            rf  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
            ra  = pick_operand();
            rb  = pick_operand();
            ren = ($urandom_range(0, 7) != 0);
            rr  = ($urandom_range(0, 49) != 0);
            step($sformatf("rand%0d", i), rr, ren, rf, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_alu
